char_buffer_writer: RTL and testbench
=====================================

CHAR_BUFFER_WRITER -- requirements
Module: char_buffer_writer

Interface
REQ-001 Parameter ROWS, default 24, text rows.
REQ-002 Parameter COLS, default 80, text columns.
REQ-003 Parameter ROW_BITS, default 5, row index width.
REQ-004 Parameter COL_BITS, default 7, column index width.
REQ-005 Parameter ADDR_BITS, default 11, char buffer address width; buffer depth = ROWS*COLS (1920).
REQ-006 Port clk, input, 1, single clock; all state SHALL update on rising edge.
REQ-007 Port reset, input, 1, synchronous, active-high.
REQ-008 Port in_data, input, 8, incoming terminal byte.
REQ-009 Port in_valid, input, 1, in_data valid.
REQ-010 Port in_ready, output, 1, block can accept a byte.
REQ-011 Port wr_en, output, 1, char buffer write strobe.
REQ-012 Port wr_address, output, ADDR_BITS, char buffer write address.
REQ-013 Port wr_data, output, 8, char buffer write data.
REQ-014 Port cursor_x, output, COL_BITS, cursor column.
REQ-015 Port cursor_y, output, ROW_BITS, cursor row (relative to top of screen).
REQ-016 Port first_char, output, ADDR_BITS, buffer address of top-left character.

Function
REQ-017 A byte SHALL be accepted only in a cycle where in_valid && in_ready; in_ready SHALL be high only in states IDLE and ESC.
REQ-018 States: INIT_CLEAR, IDLE, ESC, CLEAR; CLEAR serves both scroll and erase-line.
REQ-019 Cursor address SHALL be first_char + cursor_y*COLS + cursor_x, computed in ADDR_BITS+1 bits, with ROWS*COLS subtracted when the sum >= ROWS*COLS.
REQ-020 Printable byte (0x20-0x7E) accepted in cycle N: wr_en=1, wr_address=cursor address (pre-increment), wr_data=byte in cycle N+1; cursor_x increments in N+1 unless already COLS-1 (no autowrap; stays at COLS-1, later chars overwrite last column).
REQ-021 0x0D: cursor_x <= 0. 0x08: cursor_x decrements, saturating at 0.
REQ-022 0x0A with cursor_y < ROWS-1: cursor_y increments. With cursor_y == ROWS-1: enter CLEAR (scroll) next cycle; cursor_y unchanged.
REQ-023 0x1B: enter ESC. In ESC the next accepted byte SHALL be: 'H' cursor to (0,0); 'A' y-1 sat 0; 'B' y+1 sat ROWS-1; 'C' x+1 sat COLS-1; 'D' x-1 sat 0; 'K' enter CLEAR (erase-line); any other byte ignored. ESC SHALL return to IDLE after that byte (except 'K').
REQ-024 All other bytes (0x00-0x1F not listed, 0x7F-0xFF) SHALL be accepted and ignored.
REQ-025 Non-printable commands SHALL never assert wr_en.
REQ-026 Scroll CLEAR: exactly COLS consecutive cycles with wr_en=1, wr_data=0x20, wr_address=first_char+k (k=0..COLS-1, no wrap needed as first_char is a row multiple); in the cycle after the last write, first_char <= first_char+COLS, wrapping to 0 when result equals ROWS*COLS; state returns to IDLE.
REQ-027 Erase-line CLEAR: COLS-cursor_x consecutive writes of 0x20 starting at the cursor address, incrementing, wrapping to 0 at ROWS*COLS; cursor unchanged; then IDLE.
REQ-028 wr_en SHALL be 0 in every cycle not defined above as a write.

Reset
REQ-029 Reset SHALL force: cursor_x=0, cursor_y=0, first_char=0, wr_en=0, in_ready=0, state INIT_CLEAR, discarding any ESC or CLEAR in progress.
REQ-030 INIT_CLEAR SHALL begin the cycle after reset deasserts, write 0x20 to addresses 0..ROWS*COLS-1, one per cycle (1920 cycles), then enter IDLE with in_ready=1.
REQ-031 Reset asserted mid-INIT_CLEAR or mid-CLEAR SHALL restart INIT_CLEAR from address 0.

Verification
REQ-032 Release reset -> 1920 writes of 0x20 to addresses 0..1919 in consecutive cycles, then in_ready=1, cursor (0,0), first_char=0.
REQ-033 Send 'A' at (0,0) -> next cycle wr_en=1, wr_address=0, wr_data=0x41; cursor_x=1. 81 printable bytes -> cursor_x=79, last byte written to address 79.
REQ-034 Cursor (5,23), first_char=0, send 0x0A -> in_ready=0 for 80 cycles, writes 0x20 to 0..79, then first_char=80, cursor_y=23; with first_char=1840 -> clears 1840..1919, first_char wraps to 0.
REQ-035 first_char=1840, cursor (3,2), send 'Z' -> wr_address=(1840+160+3)-1920=83.
REQ-036 ESC 'K' at cursor (76,0), first_char=0 -> exactly 4 writes of 0x20 to 76..79; cursor unchanged. ESC 'H' -> cursor (0,0); ESC 'D' at x=0 -> x stays 0; 0x08 at x=0 -> x stays 0.
REQ-037 Assert reset during scroll clear at k=40 -> first_char=0, cursor (0,0), INIT_CLEAR restarts at address 0.

Source files
------------

// File: rtl/char_buffer_writer.sv
// Terminal byte interpreter that turns an incoming character stream into writes to a
// circular ROWS x COLS character buffer, with cursor control, line erase and scroll-by-row.
module char_buffer_writer #(
  parameter int ROWS      = 24,
  parameter int COLS      = 80,
  parameter int ROW_BITS  = 5,
  parameter int COL_BITS  = 7,
  parameter int ADDR_BITS = 11
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 wr_en,
  output logic [ADDR_BITS-1:0] wr_address,
  output logic [7:0]           wr_data,
  output logic [COL_BITS-1:0]  cursor_x,
  output logic [ROW_BITS-1:0]  cursor_y,
  output logic [ADDR_BITS-1:0] first_char
);

  localparam int                 DEPTH   = ROWS * COLS;
  localparam logic [ADDR_BITS:0] DEPTH_W = (ADDR_BITS+1)'(DEPTH);
  localparam logic [ADDR_BITS:0] COLS_W  = (ADDR_BITS+1)'(COLS);
  localparam logic [COL_BITS-1:0] X_MAX  = COL_BITS'(COLS - 1);
  localparam logic [ROW_BITS-1:0] Y_MAX  = ROW_BITS'(ROWS - 1);
  localparam logic [7:0]         BLANK   = 8'h20;

  typedef enum logic [1:0] {INIT_CLEAR, IDLE, ESC, CLEAR} state_t;

  state_t                 state_q, state_d;
  logic [COL_BITS-1:0]    cursor_x_q, cursor_x_d;
  logic [ROW_BITS-1:0]    cursor_y_q, cursor_y_d;
  logic [ADDR_BITS-1:0]   first_char_q, first_char_d;
  logic [ADDR_BITS-1:0]   clr_addr_q, clr_addr_d;
  logic [ADDR_BITS:0]     clr_left_q, clr_left_d;
  logic                   scroll_q, scroll_d;
  logic                   pr_en_q, pr_en_d;
  logic [ADDR_BITS-1:0]   pr_addr_q, pr_addr_d;
  logic [7:0]             pr_data_q, pr_data_d;
  logic [ADDR_BITS-1:0]   cur_addr;
  logic                   accept;
  logic                   clearing;

  // Adds an offset below DEPTH to a buffer address, folding back once into range.
  function automatic logic [ADDR_BITS-1:0] wrap_add(input logic [ADDR_BITS-1:0] base,
                                                    input logic [ADDR_BITS:0]   inc);
    logic [ADDR_BITS:0] sum;
    sum = {1'b0, base} + inc;
    if (sum >= DEPTH_W) sum = sum - DEPTH_W;
    return sum[ADDR_BITS-1:0];
  endfunction

  assign cur_addr = wrap_add(first_char_q,
                             (ADDR_BITS+1)'(cursor_y_q) * COLS_W + (ADDR_BITS+1)'(cursor_x_q));
  assign clearing = (state_q == INIT_CLEAR) || (state_q == CLEAR);
  assign in_ready = !reset && ((state_q == IDLE) || (state_q == ESC));
  assign accept   = in_valid && in_ready;

  assign wr_en      = !reset && (clearing || pr_en_q);
  assign wr_address = clearing ? clr_addr_q : pr_addr_q;
  assign wr_data    = clearing ? BLANK : pr_data_q;
  assign cursor_x   = cursor_x_q;
  assign cursor_y   = cursor_y_q;
  assign first_char = first_char_q;

  always_comb begin
    state_d      = state_q;
    cursor_x_d   = cursor_x_q;
    cursor_y_d   = cursor_y_q;
    first_char_d = first_char_q;
    clr_addr_d   = clr_addr_q;
    clr_left_d   = clr_left_q;
    scroll_d     = scroll_q;
    pr_en_d      = 1'b0;
    pr_addr_d    = pr_addr_q;
    pr_data_d    = pr_data_q;
    case (state_q)
      INIT_CLEAR, CLEAR: begin
        clr_addr_d = wrap_add(clr_addr_q, (ADDR_BITS+1)'(1));
        clr_left_d = clr_left_q - 1'b1;
        if (clr_left_q == (ADDR_BITS+1)'(1)) begin
          state_d = IDLE;
          if (state_q == CLEAR && scroll_q) first_char_d = wrap_add(first_char_q, COLS_W);
        end
      end
      IDLE: begin
        if (accept) begin
          if (in_data >= 8'h20 && in_data <= 8'h7E) begin
            pr_en_d   = 1'b1;
            pr_addr_d = cur_addr;
            pr_data_d = in_data;
            if (cursor_x_q != X_MAX) cursor_x_d = cursor_x_q + 1'b1;
          end else begin
            case (in_data)
              8'h0D: cursor_x_d = '0;
              8'h08: if (cursor_x_q != '0) cursor_x_d = cursor_x_q - 1'b1;
              8'h0A: begin
                if (cursor_y_q != Y_MAX) begin
                  cursor_y_d = cursor_y_q + 1'b1;
                end else begin
                  // Scroll: blank the row about to become the bottom line, then advance the origin.
                  state_d    = CLEAR;
                  clr_addr_d = first_char_q;
                  clr_left_d = COLS_W;
                  scroll_d   = 1'b1;
                end
              end
              8'h1B:   state_d = ESC;
              default: ;
            endcase
          end
        end
      end
      ESC: begin
        if (accept) begin
          state_d = IDLE;
          case (in_data)
            8'h48: begin cursor_x_d = '0; cursor_y_d = '0; end
            8'h41: if (cursor_y_q != '0) cursor_y_d = cursor_y_q - 1'b1;
            8'h42: if (cursor_y_q != Y_MAX) cursor_y_d = cursor_y_q + 1'b1;
            8'h43: if (cursor_x_q != X_MAX) cursor_x_d = cursor_x_q + 1'b1;
            8'h44: if (cursor_x_q != '0) cursor_x_d = cursor_x_q - 1'b1;
            8'h4B: begin
              state_d    = CLEAR;
              clr_addr_d = cur_addr;
              clr_left_d = COLS_W - (ADDR_BITS+1)'(cursor_x_q);
              scroll_d   = 1'b0;
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= INIT_CLEAR;
      cursor_x_q   <= '0;
      cursor_y_q   <= '0;
      first_char_q <= '0;
      clr_addr_q   <= '0;
      clr_left_q   <= DEPTH_W;
      scroll_q     <= 1'b0;
      pr_en_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cursor_x_q   <= cursor_x_d;
      cursor_y_q   <= cursor_y_d;
      first_char_q <= first_char_d;
      clr_addr_q   <= clr_addr_d;
      clr_left_q   <= clr_left_d;
      scroll_q     <= scroll_d;
      pr_en_q      <= pr_en_d;
    end
  end

  always_ff @(posedge clk) begin
    pr_addr_q <= pr_addr_d;
    pr_data_q <= pr_data_d;
  end

endmodule

// File: tb/tb_char_buffer_writer.sv
// Bench for char_buffer_writer: screen-level reference model checked every cycle,
// plus directed scenarios pinned with hand-computed literal expectations.
module tb_char_buffer_writer;

  localparam int ROWS = 24;
  localparam int COLS = 80;
  localparam int DEPTH = ROWS * COLS;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        wr_en;
  logic [10:0] wr_address;
  logic [7:0]  wr_data;
  logic [6:0]  cursor_x;
  logic [4:0]  cursor_y;
  logic [10:0] first_char;

  char_buffer_writer dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .wr_en(wr_en), .wr_address(wr_address), .wr_data(wr_data),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .first_char(first_char)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference model: screen state plus a queue of pending blanking writes.
  int   m_x, m_y, m_fc;
  bit   m_esc, m_scroll, m_pend, m_started;
  int   m_paddr;
  int   m_pdata;
  int   wq[$];

  function automatic int m_cur();
    return (m_fc + m_y * COLS + m_x) % DEPTH;
  endfunction

  task automatic model_byte(input logic [7:0] b);
    int a;
    if (m_esc) begin
      m_esc = 0;
      case (b)
        8'h48: begin m_x = 0; m_y = 0; end
        8'h41: if (m_y > 0) m_y--;
        8'h42: if (m_y < ROWS - 1) m_y++;
        8'h43: if (m_x < COLS - 1) m_x++;
        8'h44: if (m_x > 0) m_x--;
        8'h4B: begin
          a = m_cur();
          for (int k = 0; k < COLS - m_x; k++) wq.push_back((a + k) % DEPTH);
        end
        default: ;
      endcase
    end else if (b >= 8'h20 && b <= 8'h7E) begin
      m_pend = 1; m_paddr = m_cur(); m_pdata = int'(b);
      if (m_x < COLS - 1) m_x++;
    end else begin
      case (b)
        8'h0D: m_x = 0;
        8'h08: if (m_x > 0) m_x--;
        8'h0A: begin
          if (m_y < ROWS - 1) m_y++;
          else begin
            for (int k = 0; k < COLS; k++) wq.push_back(m_fc + k);
            m_scroll = 1;
          end
        end
        8'h1B: m_esc = 1;
        default: ;
      endcase
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_x = 0; m_y = 0; m_fc = 0; m_esc = 0; m_scroll = 0; m_pend = 0; m_started = 1;
      wq.delete();
      for (int i = 0; i < DEPTH; i++) wq.push_back(i);
    end else if (m_started) begin
      if (wq.size() != 0) begin
        void'(wq.pop_front());
        m_pend = 0;
        if (wq.size() == 0 && m_scroll) begin
          m_fc = (m_fc + COLS) % DEPTH;
          m_scroll = 0;
        end
      end else begin
        m_pend = 0;
        if (in_valid) model_byte(in_data);
      end
    end
  end

  // Per-cycle compare plus a write log for the directed checks.
  int wr_cnt = 0;
  int first_addr = -1;
  int last_addr = -1;
  int last_data = -1;

  always @(negedge clk) begin
    if (m_started) begin
      if (reset) begin
        chk("wr_en", 32'(wr_en), 0);
        chk("in_ready", 32'(in_ready), 0);
      end else if (wq.size() != 0) begin
        chk("wr_en", 32'(wr_en), 1);
        chk("in_ready", 32'(in_ready), 0);
        chk("clr_addr", 32'(wr_address), 32'(wq[0]));
        chk("clr_data", 32'(wr_data), 32'h20);
      end else begin
        chk("in_ready", 32'(in_ready), 1);
        chk("wr_en", 32'(wr_en), 32'(m_pend));
        if (m_pend) begin
          chk("pr_addr", 32'(wr_address), 32'(m_paddr));
          chk("pr_data", 32'(wr_data), 32'(m_pdata));
        end
      end
      chk("cursor_x", 32'(cursor_x), 32'(m_x));
      chk("cursor_y", 32'(cursor_y), 32'(m_y));
      chk("first_char", 32'(first_char), 32'(m_fc));
    end
    if (wr_en === 1'b1) begin
      if (wr_cnt == 0) first_addr = int'(wr_address);
      wr_cnt++;
      last_addr = int'(wr_address);
      last_data = int'(wr_data);
    end
  end

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) begin
      checks++; errors++;
      $display("FAIL send_timeout actual=%0d required=<5000 cycles", n);
    end else begin
      in_valid = 1'b1;
      in_data  = b;
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic esc(input logic [7:0] b);
    send(8'h1B);
    send(b);
  endtask

  task automatic settle();
    int n;
    n = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) begin
      checks++; errors++;
      $display("FAIL settle_timeout actual=%0d required=<5000 cycles", n);
    end
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(posedge clk);
    #1 wr_cnt = 0; reset = 1'b0;
    settle();
    chk("init_writes", 32'(wr_cnt), 1920);
    chk("init_first", 32'(first_addr), 0);
    chk("init_last", 32'(last_addr), 1919);
    chk("init_ready", 32'(in_ready), 1);
    chk("init_fc", 32'(first_char), 0);

    send("A"); settle();
    chk("A_addr", 32'(last_addr), 0);
    chk("A_data", 32'(last_data), 32'h41);
    chk("A_x", 32'(cursor_x), 1);
    for (int i = 0; i < 80; i++) send(8'h61 + 8'(i % 26));
    settle();
    chk("row_x_sat", 32'(cursor_x), 79);
    chk("row_last_addr", 32'(last_addr), 79);

    esc("H"); settle();
    chk("escH_x", 32'(cursor_x), 0);
    chk("escH_y", 32'(cursor_y), 0);
    send(8'h08); esc("D"); esc("A"); settle();
    chk("bs_x_sat", 32'(cursor_x), 0);
    chk("escA_y_sat", 32'(cursor_y), 0);

    for (int i = 0; i < 5; i++) esc("C");
    for (int i = 0; i < 23; i++) send(8'h0A);
    esc("B"); settle();
    chk("lf_y", 32'(cursor_y), 23);
    chk("lf_x", 32'(cursor_x), 5);
    wr_cnt = 0;
    send(8'h0A); settle();
    chk("scroll_cnt", 32'(wr_cnt), 80);
    chk("scroll_first", 32'(first_addr), 0);
    chk("scroll_last", 32'(last_addr), 79);
    chk("scroll_fc", 32'(first_char), 80);
    chk("scroll_y", 32'(cursor_y), 23);

    for (int i = 0; i < 22; i++) send(8'h0A);
    settle();
    chk("fc_1840", 32'(first_char), 1840);
    esc("H"); esc("B"); esc("B");
    for (int i = 0; i < 3; i++) esc("C");
    send("Z"); settle();
    chk("Z_addr", 32'(last_addr), 83);
    chk("Z_data", 32'(last_data), 32'h5A);

    for (int i = 0; i < 21; i++) send(8'h0A);
    wr_cnt = 0;
    send(8'h0A); settle();
    chk("wrap_cnt", 32'(wr_cnt), 80);
    chk("wrap_first", 32'(first_addr), 1840);
    chk("wrap_last", 32'(last_addr), 1919);
    chk("wrap_fc", 32'(first_char), 0);

    esc("H");
    for (int i = 0; i < 76; i++) send("k");
    settle();
    wr_cnt = 0;
    esc("K"); settle();
    chk("el_cnt", 32'(wr_cnt), 4);
    chk("el_first", 32'(first_addr), 76);
    chk("el_last", 32'(last_addr), 79);
    chk("el_x", 32'(cursor_x), 76);

    wr_cnt = 0;
    send(8'h00); send(8'h7F); send(8'hFF); send(8'h07); esc("Q"); settle();
    chk("ign_cnt", 32'(wr_cnt), 0);
    chk("ign_x", 32'(cursor_x), 76);
    send("H"); settle();
    chk("after_esc_cnt", 32'(wr_cnt), 1);
    chk("after_esc_addr", 32'(last_addr), 76);
    chk("after_esc_data", 32'(last_data), 32'h48);

    for (int i = 0; i < 23; i++) send(8'h0A);
    settle();
    wr_cnt = 0;
    send(8'h0A);
    repeat (40) @(posedge clk);
    #1;
    chk("mid_scroll_cnt", 32'(wr_cnt), 40);
    reset = 1'b1; wr_cnt = 0;
    @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_fc", 32'(first_char), 0);
    chk("rst_x", 32'(cursor_x), 0);
    chk("rst_y", 32'(cursor_y), 0);
    settle();
    chk("reinit_cnt", 32'(wr_cnt), 1920);
    chk("reinit_first", 32'(first_addr), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
